// File: rtl/relu_maxpool_pkg.sv
// Shared types and FP16 helpers for the ReLU + 2x2 max-pool stage.
package relu_maxpool_pkg;

  typedef logic [15:0] fp16_t;

  localparam int unsigned FP16_SIGN_BIT = 15;
  localparam fp16_t       FP16_ZERO     = 16'h0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Any value with the sign bit set, including -0, -inf and negative NaNs, becomes +0.
  function automatic fp16_t fp16_relu(input fp16_t x);
    return x[FP16_SIGN_BIT] ? FP16_ZERO : x;
  endfunction

  // Non-negative FP16 patterns order the same way as their unsigned integer encodings.
  function automatic fp16_t fp16_max_nonneg(input fp16_t a, input fp16_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/relu_maxpool_layer_if.sv
// Start/busy/done handshake and flattened feature-map buses for relu_maxpool_layer.
interface relu_maxpool_layer_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned H          = 10,
  parameter int unsigned W          = 10,
  parameter int unsigned CHANNELS   = 16
);
  localparam int unsigned IN_BITS  = CHANNELS * H * W * DATA_WIDTH;
  localparam int unsigned OUT_BITS = CHANNELS * (H / 2) * (W / 2) * DATA_WIDTH;

  logic                start;
  logic [IN_BITS-1:0]  in_fmap;
  logic [OUT_BITS-1:0] out_fmap;
  logic                busy;
  logic                done;

  modport master (output start, in_fmap, input  out_fmap, busy, done);
  modport slave  (input  start, in_fmap, output out_fmap, busy, done);
endinterface

// File: rtl/relu_max4.sv
// One pooling window: ReLU on four FP16 values, then their maximum.
module relu_max4
  import relu_maxpool_pkg::*;
(
  input  fp16_t i_a,
  input  fp16_t i_b,
  input  fp16_t i_c,
  input  fp16_t i_d,
  output fp16_t o_max_c
);

  fp16_t w_ab;
  fp16_t w_cd;

  assign w_ab    = fp16_max_nonneg(fp16_relu(i_a), fp16_relu(i_b));
  assign w_cd    = fp16_max_nonneg(fp16_relu(i_c), fp16_relu(i_d));
  assign o_max_c = fp16_max_nonneg(w_ab, w_cd);

endmodule

// File: rtl/relu_maxpool_layer.sv
// ReLU + 2x2/2 max pooling over a latched CHANNELS x H x W FP16 map, one output position per cycle.
module relu_maxpool_layer
  import relu_maxpool_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned H          = 10,
  parameter int unsigned W          = 10,
  parameter int unsigned CHANNELS   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  relu_maxpool_layer_if.slave  bus
);

  localparam int unsigned HO       = H / 2;
  localparam int unsigned WO       = W / 2;
  localparam int unsigned N        = HO * WO;
  localparam int unsigned RW       = $clog2(HO + 1);
  localparam int unsigned CW       = $clog2(WO + 1);
  localparam int unsigned IN_BITS  = CHANNELS * H * W * DATA_WIDTH;
  localparam int unsigned OUT_BITS = CHANNELS * N * DATA_WIDTH;

  state_t                r_state;
  logic [RW-1:0]         r_row;
  logic [CW-1:0]         r_col;
  logic [IN_BITS-1:0]    r_in;
  logic [OUT_BITS-1:0]   r_buf;
  logic [OUT_BITS-1:0]   r_out;
  logic                  r_busy;
  logic                  r_done;

  fp16_t                 w_win  [CHANNELS][4];
  fp16_t                 w_pool [CHANNELS];
  int unsigned           w_pos;

  // Window-select mux: pick the 2x2 input block under (r_row, r_col) for every channel.
  always_comb begin
    int unsigned row0;
    int unsigned col0;
    row0  = 2 * 32'(r_row);
    col0  = 2 * 32'(r_col);
    w_pos = 32'(r_row) * WO + 32'(r_col);
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      for (int unsigned k = 0; k < 4; k++) begin
        w_win[ch][k] = r_in[(ch * H * W + (row0 + k / 2) * W + col0 + k % 2) * DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pool
    relu_max4 u_relu_max4 (
      .i_a     (w_win[g][0]),
      .i_b     (w_win[g][1]),
      .i_c     (w_win[g][2]),
      .i_d     (w_win[g][3]),
      .o_max_c (w_pool[g])
    );
  end

  // Sequencer: latch input, sweep all output positions, then publish the buffer atomically.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_in    <= '0;
      r_buf   <= '0;
      r_out   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_in    <= bus.in_fmap;
            r_row   <= '0;
            r_col   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            r_buf[(ch * N + w_pos) * DATA_WIDTH +: DATA_WIDTH] <= w_pool[ch];
          end
          if (r_col == CW'(WO - 1)) begin
            r_col <= '0;
            if (r_row == RW'(HO - 1)) begin
              r_row   <= '0;
              r_state <= FINISH;
            end else begin
              r_row <= r_row + RW'(1);
            end
          end else begin
            r_col <= r_col + CW'(1);
          end
        end
        FINISH: begin
          r_out   <= r_buf;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.out_fmap = r_out;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_relu_maxpool_layer.sv
// Directed bench for relu_maxpool_layer: cycle-level reference model plus hand-computed pins.
module tb_relu_maxpool_layer;

  localparam int DW   = 16;
  localparam int H    = 10;
  localparam int W    = 10;
  localparam int CH   = 16;
  localparam int HO   = H / 2;
  localparam int WO   = W / 2;
  localparam int N    = HO * WO;
  localparam int INB  = CH * H * W * DW;
  localparam int OUTB = CH * N * DW;

  logic clk;
  logic reset;

  relu_maxpool_layer_if #(.DATA_WIDTH(DW), .H(H), .W(W), .CHANNELS(CH)) bus ();

  relu_maxpool_layer #(.DATA_WIDTH(DW), .H(H), .W(W), .CHANNELS(CH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [15:0] int_to_fp16(input int k);
    int e;
    if (k == 0) return 16'h0000;
    e = 0;
    while ((k >> (e + 1)) != 0) e++;
    return 16'(((e + 15) << 10) | ((k << (10 - e)) & 'h3FF));
  endfunction

  function automatic logic [OUTB-1:0] pool_ref(input logic [INB-1:0] f);
    logic [OUTB-1:0] o;
    o = '0;
    for (int ch = 0; ch < CH; ch++)
      for (int r = 0; r < HO; r++)
        for (int c = 0; c < WO; c++) begin
          int best;
          best = 0;
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
              int v;
              v = int'(f[((ch * H + 2 * r + dy) * W + 2 * c + dx) * DW +: DW]);
              if (v >= 32768) v = 0;
              if (v > best) best = v;
            end
          o[((ch * HO + r) * WO + c) * DW +: DW] = 16'(best);
        end
    return o;
  endfunction

  function automatic logic [15:0] oel(input logic [OUTB-1:0] v, input int ch, input int r, input int c);
    return v[((ch * HO + r) * WO + c) * DW +: DW];
  endfunction

  bit              m_busy;
  bit              m_done;
  int              m_cnt;
  logic [OUTB-1:0] m_res;
  logic [OUTB-1:0] m_out;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_cnt = 0; m_out = '0; m_res = '0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (bus.start) begin
          m_busy = 1;
          m_cnt  = 0;
          m_res  = pool_ref(bus.in_fmap);
        end
      end else begin
        m_cnt++;
        if (m_cnt == N + 1) begin
          m_busy = 0;
          m_done = 1;
          m_out  = m_res;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if (bus.busy !== m_busy) begin
        n_miss++;
        $display("FAIL busy @%0t: got %b want %b", $time, bus.busy, m_busy);
      end
      n_vec++;
      if (bus.done !== m_done) begin
        n_miss++;
        $display("FAIL done @%0t: got %b want %b", $time, bus.done, m_done);
      end
      n_vec++;
      if (bus.out_fmap !== m_out) begin
        n_miss++;
        for (int i = 0; i < CH * N; i++)
          if (bus.out_fmap[i * DW +: DW] !== m_out[i * DW +: DW]) begin
            $display("FAIL out_fmap @%0t: elem %0d got %h want %h", $time, i,
                     bus.out_fmap[i * DW +: DW], m_out[i * DW +: DW]);
            break;
          end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(inout logic [INB-1:0] f, input int ch, input int y, input int x, input logic [15:0] v);
    f[((ch * H + y) * W + x) * DW +: DW] = v;
  endtask

  task automatic do_start(input logic [INB-1:0] f);
    bus.in_fmap = f;
    bus.start   = 1'b1;
    step();
    bus.start   = 1'b0;
  endtask

  // Waits for done; optionally re-pulses start at cycle poke. edges = cycles after start edge.
  task automatic wait_done(input int poke, output int edges, output int busy_n, output bit ok);
    edges = 0; busy_n = 0; ok = 0;
    for (int i = 0; i < 80; i++) begin
      if (bus.done) begin
        ok = 1;
        edges = i;
        break;
      end
      if (bus.busy) busy_n++;
      bus.start = (i == poke);
      step();
    end
    bus.start = 1'b0;
    if (!ok) begin
      n_vec++;
      n_miss++;
      $display("FAIL done_timeout: got no done within 80 cycles, want one");
    end
  endtask

  logic [INB-1:0] ramp, alt, spec, chan;
  int  edges, busy_n, dones;
  bit  ok;

  initial begin
    bus.start   = 1'b0;
    bus.in_fmap = '0;
    reset       = 1'b1;
    ramp = '0; alt = '0; spec = '0; chan = '0;
    for (int ch = 0; ch < CH; ch++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) begin
          put(ramp, ch, y, x, int_to_fp16((y * W + x) % 32));
          put(alt,  ch, y, x, 16'h7C00);
          put(chan, ch, y, x, int_to_fp16(ch));
        end
    put(spec, 0, 0, 0, 16'hBC00); put(spec, 0, 0, 1, 16'h8000); put(spec, 0, 1, 0, 16'hFC00); put(spec, 0, 1, 1, 16'hC200);
    put(spec, 1, 0, 0, 16'hBC00); put(spec, 1, 0, 1, 16'h3800); put(spec, 1, 1, 0, 16'h4200); put(spec, 1, 1, 1, 16'h3C00);
    put(spec, 2, 0, 0, 16'h7C00); put(spec, 2, 0, 1, 16'h7BFF); put(spec, 2, 1, 0, 16'h3C00);
    put(spec, 3, 0, 0, 16'h7E00); put(spec, 3, 0, 1, 16'h7C00);
    put(spec, 4, 0, 0, 16'hFE00); put(spec, 4, 0, 1, 16'h0001);

    step(); step();
    chk("reset_out_ch0_00", 32'(oel(bus.out_fmap, 0, 0, 0)), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_done", 32'(bus.done), 32'h0);
    reset = 1'b0;
    step();
    chk_en = 1;

    // Ramp map, second start at cycle 10 ignored, input changed after start edge.
    do_start(ramp);
    bus.in_fmap = alt;
    wait_done(10, edges, busy_n, ok);
    chk("ramp_latency", 32'(edges), 32'd26);
    chk("ramp_busy_cycles", 32'(busy_n), 32'd26);
    chk("ramp_ch0_r3c1", 32'(oel(bus.out_fmap, 0, 3, 1)), 32'h4FC0);
    chk("ramp_ch15_r0c0", 32'(oel(bus.out_fmap, 15, 0, 0)), 32'h4980);
    chk("model_ramp_r3c1", 32'(oel(m_out, 7, 3, 1)), 32'h4FC0);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.done) dones++;
    end
    chk("ramp_single_done", 32'(dones), 32'd0);

    // Negative / mixed / special-value windows; then restart in the done cycle.
    do_start(spec);
    wait_done(-1, edges, busy_n, ok);
    chk("neg_window", 32'(oel(bus.out_fmap, 0, 0, 0)), 32'h0000);
    chk("mixed_window", 32'(oel(bus.out_fmap, 1, 0, 0)), 32'h4200);
    chk("inf_window", 32'(oel(bus.out_fmap, 2, 0, 0)), 32'h7C00);
    chk("nan_window", 32'(oel(bus.out_fmap, 3, 0, 0)), 32'h7E00);
    chk("negnan_window", 32'(oel(bus.out_fmap, 4, 0, 0)), 32'h0001);
    chk("model_mixed", 32'(oel(m_out, 1, 0, 0)), 32'h4200);
    do_start(chan);
    wait_done(-1, edges, busy_n, ok);
    chk("b2b_latency", 32'(edges), 32'd26);
    for (int ch = 0; ch < CH; ch++)
      for (int p = 0; p < N; p++)
        chk($sformatf("chan_%0d_%0d", ch, p), 32'(oel(bus.out_fmap, ch, p / WO, p % WO)), 32'(int_to_fp16(ch)));
    chk("model_ch15", 32'(oel(m_out, 15, 4, 4)), 32'h4B80);

    // Reset mid-RUN, then a clean run.
    step();
    do_start(ramp);
    for (int i = 0; i < 11; i++) step();
    reset = 1'b1;
    step();
    chk("midrst_out", 32'(oel(bus.out_fmap, 15, 4, 4)), 32'h0);
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.done) dones++;
    end
    chk("midrst_no_done", 32'(dones), 32'd0);
    do_start(ramp);
    wait_done(-1, edges, busy_n, ok);
    chk("post_rst_latency", 32'(edges), 32'd26);
    chk("post_rst_r3c1", 32'(oel(bus.out_fmap, 9, 3, 1)), 32'h4FC0);
    step(); step();

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
